// File: rtl/axil_rr_master.sv
// Two-client round-robin AXI-Lite master. It arbitrates single-beat read and
// write requests from two req/ack clients onto one AXI-Lite master port. Only
// one transaction is in flight at a time.
//
// Client handshake: a client raises cN_req with we/addr/wdata stable and keeps
// them stable until cN_ack. cN_ack is a one-cycle pulse. cN_rdata and cN_err
// are valid in the ack cycle.
// AXI handshake: a beat transfers on a rising edge where valid && ready. Every
// master valid/ready is a flop, so none depends combinationally on an input
// ready/valid. A valid stays high until its ready has been seen.
module axil_rr_master #(
    parameter int AXI_LITE_ADDR_WIDTH = 8
) (
    input  logic                           aclk,
    input  logic                           resetn,
    input  logic                           c0_req,
    input  logic                           c0_we,
    input  logic [AXI_LITE_ADDR_WIDTH-1:0] c0_addr,
    input  logic [31:0]                    c0_wdata,
    output logic                           c0_ack,
    output logic [31:0]                    c0_rdata,
    output logic                           c0_err,
    input  logic                           c1_req,
    input  logic                           c1_we,
    input  logic [AXI_LITE_ADDR_WIDTH-1:0] c1_addr,
    input  logic [31:0]                    c1_wdata,
    output logic                           c1_ack,
    output logic [31:0]                    c1_rdata,
    output logic                           c1_err,
    output logic [AXI_LITE_ADDR_WIDTH-1:0] m_awaddr,
    output logic                           m_awvalid,
    input  logic                           m_awready,
    output logic [31:0]                    m_wdata,
    output logic                           m_wvalid,
    input  logic                           m_wready,
    input  logic [1:0]                     m_bresp,
    input  logic                           m_bvalid,
    output logic                           m_bready,
    output logic [AXI_LITE_ADDR_WIDTH-1:0] m_araddr,
    output logic                           m_arvalid,
    input  logic                           m_arready,
    input  logic [31:0]                    m_rdata,
    input  logic [1:0]                     m_rresp,
    input  logic                           m_rvalid,
    output logic                           m_rready,
    output logic [2:0]                     dbg_state
);
    localparam int AW = AXI_LITE_ADDR_WIDTH;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WRITE = 3'd1,
        S_WRESP = 3'd2,
        S_RADDR = 3'd3,
        S_RDATA = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t        state_q, state_d;
    logic          last_grant_q, last_grant_d;
    logic          grant_q, grant_d;
    logic          we_q, we_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic          awvalid_q, awvalid_d;
    logic          wvalid_q, wvalid_d;
    logic          aw_done_q, aw_done_d;
    logic          w_done_q, w_done_d;
    logic          bready_q, bready_d;
    logic          arvalid_q, arvalid_d;
    logic          rready_q, rready_d;
    logic          ack0_q, ack0_d;
    logic          ack1_q, ack1_d;
    logic [31:0]   rdata0_q, rdata0_d;
    logic [31:0]   rdata1_q, rdata1_d;
    logic          err0_q, err0_d;
    logic          err1_q, err1_d;

    // Arbitration: a tie goes to the client that was not granted last.
    logic          pick1;
    logic          sel_we;
    logic [AW-1:0] sel_addr;
    logic [31:0]   sel_wdata;
    logic          aw_fin;
    logic          w_fin;
    logic          unused_resp_lsb;

    assign pick1     = c1_req && (!c0_req || !last_grant_q);
    assign sel_we    = pick1 ? c1_we    : c0_we;
    assign sel_addr  = pick1 ? c1_addr  : c0_addr;
    assign sel_wdata = pick1 ? c1_wdata : c0_wdata;
    assign aw_fin    = aw_done_q || (awvalid_q && m_awready);
    assign w_fin     = w_done_q  || (wvalid_q  && m_wready);
    assign unused_resp_lsb = m_bresp[0] ^ m_rresp[0];

    // Next-state and next-output logic for the transaction sequencer.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        grant_d      = grant_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        awvalid_d    = awvalid_q;
        wvalid_d     = wvalid_q;
        aw_done_d    = aw_done_q;
        w_done_d     = w_done_q;
        bready_d     = bready_q;
        arvalid_d    = arvalid_q;
        rready_d     = rready_q;
        ack0_d       = ack0_q;
        ack1_d       = ack1_q;
        rdata0_d     = rdata0_q;
        rdata1_d     = rdata1_q;
        err0_d       = err0_q;
        err1_d       = err1_q;
        case (state_q)
            S_IDLE: begin
                if (c0_req || c1_req) begin
                    grant_d      = pick1;
                    last_grant_d = pick1;
                    we_d         = sel_we;
                    addr_d       = sel_addr;
                    wdata_d      = sel_wdata;
                    if (sel_we) begin
                        state_d   = S_WRITE;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                    end else begin
                        state_d   = S_RADDR;
                        arvalid_d = 1'b1;
                    end
                end
            end
            S_WRITE: begin
                // AW and W complete independently; each valid drops after its own ready.
                if (awvalid_q && m_awready) begin
                    awvalid_d = 1'b0;
                    aw_done_d = 1'b1;
                end
                if (wvalid_q && m_wready) begin
                    wvalid_d = 1'b0;
                    w_done_d = 1'b1;
                end
                if (aw_fin && w_fin) begin
                    state_d   = S_WRESP;
                    bready_d  = 1'b1;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                end
            end
            S_WRESP: begin
                if (m_bvalid) begin
                    bready_d = 1'b0;
                    state_d  = S_DONE;
                    if (grant_q) begin
                        err1_d = m_bresp[1];
                        ack1_d = 1'b1;
                    end else begin
                        err0_d = m_bresp[1];
                        ack0_d = 1'b1;
                    end
                end
            end
            S_RADDR: begin
                if (m_arready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = S_RDATA;
                end
            end
            S_RDATA: begin
                if (m_rvalid) begin
                    rready_d = 1'b0;
                    state_d  = S_DONE;
                    if (grant_q) begin
                        rdata1_d = m_rdata;
                        err1_d   = m_rresp[1];
                        ack1_d   = 1'b1;
                    end else begin
                        rdata0_d = m_rdata;
                        err0_d   = m_rresp[1];
                        ack0_d   = 1'b1;
                    end
                end
            end
            S_DONE: begin
                ack0_d  = 1'b0;
                ack1_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and registered outputs; reset aborts any transaction without an ack.
    always_ff @(posedge aclk) begin
        if (!resetn) begin
            state_q      <= S_IDLE;
            last_grant_q <= 1'b1;
            grant_q      <= 1'b0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            awvalid_q    <= 1'b0;
            wvalid_q     <= 1'b0;
            aw_done_q    <= 1'b0;
            w_done_q     <= 1'b0;
            bready_q     <= 1'b0;
            arvalid_q    <= 1'b0;
            rready_q     <= 1'b0;
            ack0_q       <= 1'b0;
            ack1_q       <= 1'b0;
            rdata0_q     <= '0;
            rdata1_q     <= '0;
            err0_q       <= 1'b0;
            err1_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            grant_q      <= grant_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            awvalid_q    <= awvalid_d;
            wvalid_q     <= wvalid_d;
            aw_done_q    <= aw_done_d;
            w_done_q     <= w_done_d;
            bready_q     <= bready_d;
            arvalid_q    <= arvalid_d;
            rready_q     <= rready_d;
            ack0_q       <= ack0_d;
            ack1_q       <= ack1_d;
            rdata0_q     <= rdata0_d;
            rdata1_q     <= rdata1_d;
            err0_q       <= err0_d;
            err1_q       <= err1_d;
        end
    end

    assign m_awaddr  = addr_q;
    assign m_araddr  = addr_q;
    assign m_wdata   = wdata_q;
    assign m_awvalid = awvalid_q;
    assign m_wvalid  = wvalid_q;
    assign m_bready  = bready_q;
    assign m_arvalid = arvalid_q;
    assign m_rready  = rready_q;
    assign c0_ack    = ack0_q;
    assign c1_ack    = ack1_q;
    assign c0_rdata  = rdata0_q;
    assign c1_rdata  = rdata1_q;
    assign c0_err    = err0_q;
    assign c1_err    = err1_q;
    assign dbg_state = state_q;

endmodule

// File: doc/axil_rr_master.md
# axil_rr_master

Two-client round-robin AXI-Lite master that shares one AXI-Lite register-file slave (the `data_mem` register bank) between two internal requesters, e.g. a control sequencer and a host bridge. Each client issues single-beat read or write transactions over a simple req/ack interface. The block arbitrates between them, drives the full AXI-Lite handshake on one master port, and returns data and response status to the granted client. Only one transaction is outstanding at a time.

## Interface
- `AXI_LITE_ADDR_WIDTH`, 8, byte-address width of the master port and of the client addresses.
- `aclk`  in  1  clock; all logic is rising-edge.
- `resetn`  in  1  reset, synchronous, active-low.
- `c0_req`, `c1_req`  in  1 each  client request; held high until the matching ack.
- `c0_we`, `c1_we`  in  1 each  1 = write, 0 = read; held stable with `cN_req`.
- `c0_addr`, `c1_addr`  in  AXI_LITE_ADDR_WIDTH each  byte address; held stable with `cN_req`.
- `c0_wdata`, `c1_wdata`  in  32 each  write data; held stable with `cN_req`.
- `c0_ack`, `c1_ack`  out  1 each  one-cycle completion pulse.
- `c0_rdata`, `c1_rdata`  out  32 each  read data; valid in the ack cycle and held until the next ack to that client.
- `c0_err`, `c1_err`  out  1 each  response error flag; valid in the ack cycle.
- `m_awaddr`  out  AXI_LITE_ADDR_WIDTH; `m_awvalid`  out  1; `m_awready`  in  1.
- `m_wdata`  out  32; `m_wvalid`  out  1; `m_wready`  in  1.
- `m_bresp`  in  2; `m_bvalid`  in  1; `m_bready`  out  1.
- `m_araddr`  out  AXI_LITE_ADDR_WIDTH; `m_arvalid`  out  1; `m_arready`  in  1.
- `m_rdata`  in  32; `m_rresp`  in  2; `m_rvalid`  in  1; `m_rready`  out  1.

## Operation
- States: IDLE, WRITE, WRESP, RADDR, RDATA, DONE.
- IDLE: sample `c0_req` and `c1_req`.
  - If exactly one is high, grant it.
  - If both are high, grant the client that was not granted last (`last_grant` register).
  - Latch the granted client's we, addr and wdata into internal registers, set `grant`, update `last_grant`.
  - Go to WRITE if we = 1, otherwise RADDR.
- WRITE:
  - Assert `m_awvalid` and `m_wvalid` independently.
  - Each valid drops in the cycle after its own ready is seen high; track this with flags `aw_done` and `w_done`.
  - When both handshakes are complete (both may complete in the same cycle), go to WRESP.
- WRESP: `m_bready` = 1. On `m_bvalid`, capture err = `m_bresp[1]` and go to DONE.
- RADDR: `m_arvalid` = 1. On `m_arready`, go to RDATA.
- RDATA: `m_rready` = 1. On `m_rvalid`, capture `m_rdata` into the granted client's rdata register, capture err = `m_rresp[1]`, and go to DONE.
- DONE:
  - Pulse `cN_ack` for the granted client only, for one cycle, then return to IDLE.
  - A client sees ack, drops req in the following cycle, or re-asserts for back-to-back use.
- Address, wdata and we are taken from the latched registers, never from the live client inputs after grant.
- A request that is raised while another transaction is in progress waits. It is evaluated on the next IDLE.
- Fairness: with both clients requesting continuously, grants alternate 0,1,0,1.
- `m_awaddr`, `m_araddr` and `m_wdata` are driven from the latched registers at all times and are 0 after reset.

## Timing
- Reset (`resetn` low at a rising edge):
  - state = IDLE, `last_grant` = 1 (client 0 wins the first tie).
  - All valids, readies and acks = 0; `cN_rdata` = 0; `cN_err` = 0; latched address and data = 0.
- Reset mid-transaction aborts immediately. No ack is issued, and the master valids drop in the next cycle.
- Minimum latency, from the IDLE cycle that samples req to the ack cycle, against a zero-wait slave:
  - Write: IDLE, WRITE, WRESP, DONE = ack 3 cycles after the sampling edge.
  - Read: IDLE, RADDR, RDATA, DONE = ack 3 cycles after the sampling edge.
- Against `data_mem` (bvalid 2 cycles after aw/w accepted; rvalid 2 cycles after ar accepted):
  - Write ack: 5 cycles after sampling.
  - Read ack: 5 cycles after sampling.
- The minimum gap between successive grants is 1 IDLE cycle after DONE.
- AXI rules:
  - A valid is never withdrawn before its ready.
  - No valid depends combinationally on a ready.
  - `m_bready` is high only in WRESP; `m_rready` is high only in RDATA.
- There is no timeout. A slave that never responds stalls the block until reset.

## Test plan
- Single write: c0 writes addr 0x08, data 0xDEADBEEF to `data_mem`.
  - Expect `m_awaddr` = 0x08, `m_wdata` = 0xDEADBEEF, and `c0_ack` exactly once with `c0_err` = 0.
  - Then c1 reads 0x08: `c1_rdata` = 0xDEADBEEF, `c1_err` = 0.
- Simultaneous requests from reset: c0 reads 0x00, c1 reads 0x04.
  - Expect the c0 grant first, with `c0_rdata` = 0x00640064.
  - Then c1, with `c1_rdata` = 0xFF9CFF9C.
- Continuous contention: both clients hold req for 6 transactions.
  - Expect the ack order c0,c1,c0,c1,c0,c1.
  - Expect no ack on a client whose req is low.
- Split handshake: the slave model holds `m_wready` low for 3 cycles after `m_awready`.
  - Expect `m_awvalid` to drop after aw acceptance while `m_wvalid` stays high.
  - Expect WRESP entered only after the w handshake.
- Error response: the slave returns bresp = 2'b10 for a write, then rresp = 2'b10 for a read.
  - Expect `c0_err` = 1 in each ack cycle.
- Reset mid-RDATA: deassert `resetn` for 1 cycle while waiting for rvalid.
  - Expect no ack, all master valids and readies = 0, and state IDLE.
  - A new c1 read then completes normally.
